mlp_pair_sequencer: RTL and testbench

Drives the neuron multiply-accumulate datapath from a host byte stream. The host loads up to DEPTH packed activation/weight nibble pairs into an internal buffer. A `start` pulse then triggers the sequencer to clear the accumulator, replay one pair per cycle into the MAC, and capture the final ReLU result. It sits between the host-facing pins and the MAC/accumulator core, and is the producing end of that core's `(i, w)` input interface.

---
 rtl/mlp_pair_sequencer.sv | 99 +++++++++
 tb/tb_mlp_pair_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mlp_pair_sequencer.sv
// rtl/mlp_pair_sequencer.sv - buffers host nibble pairs and replays them into the MAC on start.
// Optional MLP_SEQ_REPLAY_EN keeps the buffered pairs after a run so the next start replays them.
module mlp_pair_sequencer #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          flush,
  input  logic          start,
  output logic          busy,
  output logic [3:0]    mac_i,
  output logic [3:0]    mac_w,
  output logic          mac_clear,
  input  logic [15:0]   acc_relu,
  output logic [15:0]   result,
  output logic          result_valid,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, SETTLE} state_t;

  state_t        state, state_nxt;
  logic [7:0]    pair_buf [DEPTH];
  logic [CW-1:0] rd_ptr;
  logic [7:0]    cur_pair;
  logic          accept;

  assign cur_pair = pair_buf[rd_ptr[AW-1:0]];
  assign accept   = load_valid && load_ready;

  // Nibbles reach the MAC only in RUN so the free-running accumulator holds elsewhere.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    mac_clear  = 1'b0;
    mac_i      = 4'd0;
    mac_w      = 4'd0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        load_ready = (count < DEPTH_C) && !flush;
        if (start && (count != '0)) state_nxt = CLEAR;
      end
      CLEAR: begin
        mac_clear = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        mac_i = cur_pair[3:0];
        mac_w = cur_pair[7:4];
        if (rd_ptr == count - CW'(1)) state_nxt = SETTLE;
      end
      SETTLE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      rd_ptr       <= '0;
      result       <= 16'd0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush)       count <= '0;
          else if (accept) count <= count + CW'(1);
        end
        CLEAR: rd_ptr <= '0;
        RUN:   rd_ptr <= rd_ptr + CW'(1);
        SETTLE: begin
          result       <= acc_relu;
          result_valid <= 1'b1;
`ifndef MLP_SEQ_REPLAY_EN
          count        <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Pair storage carries no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (accept) pair_buf[count[AW-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_mlp_pair_sequencer.sv
// tb/tb_mlp_pair_sequencer.sv - directed bench for mlp_pair_sequencer with a behavioural MAC.
module tb_mlp_pair_sequencer;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [7:0]    load_data = 8'd0;
  logic          load_ready;
  logic          flush = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic [3:0]    mac_i, mac_w;
  logic          mac_clear;
  logic [15:0]   acc_relu;
  logic [15:0]   result;
  logic          result_valid;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mlp_pair_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .flush(flush), .start(start), .busy(busy),
    .mac_i(mac_i), .mac_w(mac_w), .mac_clear(mac_clear), .acc_relu(acc_relu),
    .result(result), .result_valid(result_valid), .count(count)
  );

  // MAC model: registered total, combinational relu(total + i*w).
  logic signed [15:0] total = 16'sd0;
  logic signed [7:0]  prod;
  logic signed [15:0] sum;
  assign prod     = $signed(mac_i) * $signed(mac_w);
  assign sum      = total + {{8{prod[7]}}, prod};
  assign acc_relu = sum[15] ? 16'd0 : sum;
  always @(posedge clk) total <= mac_clear ? 16'sd0 : sum;

  task automatic load_pair(input logic [3:0] i, input logic [3:0] w);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = {w, i};
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic do_run(input int limit, output int lat, output int busy_cyc,
                        output int clr_cyc, output logic seen);
    lat = 0; busy_cyc = 0; clr_cyc = 0; seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= limit && !seen; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cyc++;
      if (mac_clear) clr_cyc++;
      if (result_valid) begin seen = 1'b1; lat = c; end
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (result !== 16'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b exp=0", result_valid); end
    checks++; if (mac_clear !== 1'b0 || mac_i !== 4'd0 || mac_w !== 4'd0) begin failures++; $display("FAIL reset_mac got=%b/%h/%h exp=0/0/0", mac_clear, mac_i, mac_w); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
  endtask

  task automatic test_basic_run();
    int lat, bc, cc; logic seen;
    do_flush();
    load_pair(4'd2, 4'd3);
    load_pair(4'hF, 4'd4);
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL basic_count got=%0d exp=2", count); end
    do_run(20, lat, bc, cc, seen);
    checks++; if (!seen || lat != 5) begin failures++; $display("FAIL basic_latency got=%0d seen=%b exp=5", lat, seen); end
    checks++; if (result !== 16'd2) begin failures++; $display("FAIL basic_result got=%0d exp=2", result); end
    checks++; if (cc != 1) begin failures++; $display("FAIL basic_clear_pulses got=%0d exp=1", cc); end
  endtask

  task automatic test_negative_clip();
    int lat, bc, cc; logic seen;
    do_flush();
    load_pair(4'h8, 4'd7);
    do_run(20, lat, bc, cc, seen);
    checks++; if (!seen || result !== 16'd0) begin failures++; $display("FAIL clip_result got=%0d seen=%b exp=0", result, seen); end
    checks++; if (bc != 3) begin failures++; $display("FAIL clip_busy_cycles got=%0d exp=3", bc); end
  endtask

  task automatic test_full_buffer();
    int lat, bc, cc; logic seen;
    do_flush();
    for (int k = 0; k < DEPTH; k++) load_pair(4'd7, 4'd7);
    @(negedge clk);
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL full_load_ready got=%b exp=0", load_ready); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
    load_pair(4'd1, 4'd1);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_count_after_extra got=%0d exp=8", count); end
    do_run(40, lat, bc, cc, seen);
    checks++; if (!seen || result !== 16'd392) begin failures++; $display("FAIL full_result got=%0d seen=%b exp=392", result, seen); end
    checks++; if (lat != 11) begin failures++; $display("FAIL full_latency got=%0d exp=11", lat); end
  endtask

  task automatic test_empty_and_flush();
    int lat, bc, cc; logic seen;
    do_flush();
    do_run(8, lat, bc, cc, seen);
    checks++; if (seen || bc != 0) begin failures++; $display("FAIL empty_start got rv=%b busy_cycles=%0d exp=0/0", seen, bc); end
    load_pair(4'd3, 4'd3);
    @(negedge clk);
    flush = 1'b1; load_valid = 1'b1; load_data = 8'h55;
    #1;
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL flush_load_ready got=%b exp=0", load_ready); end
    @(posedge clk); #1;
    flush = 1'b0; load_valid = 1'b0;
    checks++; if (count !== '0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    int lat, bc, cc; logic seen;
    do_flush();
    load_pair(4'd1, 4'd5);
    do_run(20, lat, bc, cc, seen);
    checks++; if (!seen || result !== 16'd5) begin failures++; $display("FAIL run1_result got=%0d seen=%b exp=5", result, seen); end
`ifdef MLP_SEQ_REPLAY_EN
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL run1_count got=%0d exp=1", count); end
    do_run(20, lat, bc, cc, seen);
    checks++; if (!seen || result !== 16'd5 || lat != 4) begin failures++; $display("FAIL replay_result got=%0d lat=%0d seen=%b exp=5/4", result, lat, seen); end
`else
    checks++; if (count !== '0) begin failures++; $display("FAIL run1_count got=%0d exp=0", count); end
    do_run(8, lat, bc, cc, seen);
    checks++; if (seen || bc != 0) begin failures++; $display("FAIL consumed_start got rv=%b busy_cycles=%0d exp=0/0", seen, bc); end
`endif
  endtask

  task automatic test_reset_mid_run();
    do_flush();
    load_pair(4'd3, 4'd2);
    load_pair(4'd1, 4'd1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (mac_clear !== 1'b1) begin failures++; $display("FAIL mid_clear got=%b exp=1", mac_clear); end
    @(negedge clk);
    checks++; if (busy !== 1'b1 || mac_i !== 4'd3 || mac_w !== 4'd2) begin failures++; $display("FAIL mid_run_out got=%b/%h/%h exp=1/3/2", busy, mac_i, mac_w); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || mac_i !== 4'd0 || mac_w !== 4'd0 || result_valid !== 1'b0) begin failures++; $display("FAIL async_reset_out got=%b/%h/%h/%b exp=0/0/0/0", busy, mac_i, mac_w, result_valid); end
    checks++; if (result !== 16'd0 || count !== '0) begin failures++; $display("FAIL async_reset_regs got=%0d/%0d exp=0/0", result, count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || count !== '0 || load_ready !== 1'b1) begin failures++; $display("FAIL post_reset got=%b/%0d/%b exp=0/0/1", busy, count, load_ready); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_run();
    test_negative_clip();
    test_full_buffer();
    test_empty_and_flush();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
